// File: rtl/spram_arbiter_pkg.sv
// Shared types and defaults for the two-requester SPRAM arbiter.
package spram_arbiter_pkg;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  localparam int DEF_ADDR_BITS = 15;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_BURST = 4;

  function automatic int cnt_width(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWNER_A) ? OWNER_B : OWNER_A;
  endfunction

endpackage

// File: rtl/spram_arbiter_if.sv
// One requester port of the arbiter: req/gnt handshake plus read return.
interface spram_arbiter_if
  import spram_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int WIDTH     = DEF_WIDTH
);
  logic                 req;
  logic                 wren;
  logic [ADDR_BITS-1:0] addr;
  logic [WIDTH-1:0]     wdata;
  logic                 gnt;
  logic                 rvalid;
  logic [WIDTH-1:0]     rdata;

  modport master (
    output req, wren, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, wren, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/spram_arbiter_rr_pick.sv
// Combinational two-way pick: a lone request always wins; under contention
// the previous owner keeps the RAM only while its burst allowance lasts.
module spram_arbiter_rr_pick
  import spram_arbiter_pkg::*;
(
  input  logic   a_req_i,
  input  logic   b_req_i,
  input  owner_e last_i,
  input  logic   burst_ok_i,
  output logic   a_gnt_o,
  output logic   b_gnt_o
);
  owner_e winner;

  always_comb begin
    winner  = burst_ok_i ? last_i : other_owner(last_i);
    a_gnt_o = 1'b0;
    b_gnt_o = 1'b0;
    if (a_req_i && b_req_i) begin
      a_gnt_o = (winner == OWNER_A);
      b_gnt_o = (winner == OWNER_B);
    end else begin
      a_gnt_o = a_req_i;
      b_gnt_o = b_req_i;
    end
  end
endmodule

// File: rtl/spram_arbiter.sv
// Shares one single-ported SPRAM between requesters A and B with round-robin,
// burst-bounded arbitration; read data returns one cycle after the grant.
module spram_arbiter
  import spram_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                 clk,
  input  logic                 reset,
  spram_arbiter_if.slave       a_if,
  spram_arbiter_if.slave       b_if,
  output logic                 mem_cs_o,
  output logic                 mem_wren_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [WIDTH-1:0]     mem_wdata_o,
  input  logic [WIDTH-1:0]     mem_rdata_i
);
  localparam int              CNT_W   = cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(MAX_BURST - 1);

  owner_e           last_q, last_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             prev_gnt_q, prev_gnt_d;
  logic             a_rvalid_q, a_rvalid_d;
  logic             b_rvalid_q, b_rvalid_d;

  logic             a_gnt, b_gnt, gnt_any, burst_ok, same_owner;
  owner_e           gnt_owner;

  // Continuing a burst needs a grant in the immediately preceding cycle.
  assign burst_ok = prev_gnt_q && (burst_cnt_q < CNT_TOP);

  spram_arbiter_rr_pick u_pick (
    .a_req_i    (a_if.req & ~reset),
    .b_req_i    (b_if.req & ~reset),
    .last_i     (last_q),
    .burst_ok_i (burst_ok),
    .a_gnt_o    (a_gnt),
    .b_gnt_o    (b_gnt)
  );

  assign gnt_any     = a_gnt | b_gnt;
  assign gnt_owner   = b_gnt ? OWNER_B : OWNER_A;
  assign same_owner  = gnt_any && prev_gnt_q && (gnt_owner == last_q);

  assign a_if.gnt    = a_gnt;
  assign b_if.gnt    = b_gnt;
  assign a_if.rvalid = a_rvalid_q;
  assign b_if.rvalid = b_rvalid_q;
  assign a_if.rdata  = mem_rdata_i;
  assign b_if.rdata  = mem_rdata_i;

  always_comb begin
    mem_cs_o    = gnt_any;
    mem_wren_o  = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (a_gnt) begin
      mem_wren_o  = a_if.wren;
      mem_addr_o  = a_if.addr;
      mem_wdata_o = a_if.wdata;
    end else if (b_gnt) begin
      mem_wren_o  = b_if.wren;
      mem_addr_o  = b_if.addr;
      mem_wdata_o = b_if.wdata;
    end
  end

  always_comb begin
    last_d      = gnt_any ? gnt_owner : last_q;
    prev_gnt_d  = gnt_any;
    burst_cnt_d = '0;
    // A lone requester can be granted indefinitely; the count saturates.
    if (same_owner) begin
      burst_cnt_d = (burst_cnt_q == CNT_TOP) ? burst_cnt_q : burst_cnt_q + CNT_W'(1);
    end
    a_rvalid_d  = a_gnt & ~a_if.wren;
    b_rvalid_d  = b_gnt & ~b_if.wren;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= OWNER_B;
      burst_cnt_q <= '0;
      prev_gnt_q  <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
    end else begin
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      prev_gnt_q  <= prev_gnt_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
    end
  end
endmodule

// File: tb/tb_spram_arbiter.sv
// Scoreboard bench: two arbiters (MAX_BURST 4 and 1) each with a behavioural SPRAM.
module tb_spram_arbiter;
  import spram_arbiter_pkg::*;

  localparam int AB = 15;
  localparam int W  = 8;
  localparam int NI = 2;

  typedef struct {
    bit          ga, gb, rva, rvb, wren;
    bit [AB-1:0] addr;
    bit [W-1:0]  wdata;
  } rec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // stimulus drive, index [instance][port], port 0 = A, 1 = B
  logic          req_d   [NI][2];
  logic          wren_d  [NI][2];
  logic [AB-1:0] addr_d  [NI][2];
  logic [W-1:0]  wdata_d [NI][2];

  int n_tests = 0;
  int n_fail  = 0;

  rec_t     expq [NI][$];
  bit [7:0] rdq  [NI*2][$];

  function automatic bit [7:0] init_val(int k, int i);
    return 8'(i * 7 + k * 3 + 1);
  endfunction

  function automatic int mb_of(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic check(int k, string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL inst%0d %s: got 0x%0h expected 0x%0h at t=%0t", k, name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int MB = (gi == 0) ? 4 : 1;

    spram_arbiter_if #(.ADDR_BITS(AB), .WIDTH(W)) a_if ();
    spram_arbiter_if #(.ADDR_BITS(AB), .WIDTH(W)) b_if ();

    logic          mcs, mwren;
    logic [AB-1:0] maddr;
    logic [W-1:0]  mwdata;
    logic [W-1:0]  mrdata = '0;
    bit   [7:0]    mem [1 << AB];
    logic          gnt_l [2];
    logic          rv_l  [2];
    logic [W-1:0]  rd_l  [2];
    int            waitc [2] = '{0, 0};

    assign a_if.req   = req_d[gi][0];
    assign a_if.wren  = wren_d[gi][0];
    assign a_if.addr  = addr_d[gi][0];
    assign a_if.wdata = wdata_d[gi][0];
    assign b_if.req   = req_d[gi][1];
    assign b_if.wren  = wren_d[gi][1];
    assign b_if.addr  = addr_d[gi][1];
    assign b_if.wdata = wdata_d[gi][1];
    assign gnt_l[0] = a_if.gnt;
    assign gnt_l[1] = b_if.gnt;
    assign rv_l[0]  = a_if.rvalid;
    assign rv_l[1]  = b_if.rvalid;
    assign rd_l[0]  = a_if.rdata;
    assign rd_l[1]  = b_if.rdata;

    spram_arbiter #(.ADDR_BITS(AB), .WIDTH(W), .MAX_BURST(MB)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .a_if        (a_if),
      .b_if        (b_if),
      .mem_cs_o    (mcs),
      .mem_wren_o  (mwren),
      .mem_addr_o  (maddr),
      .mem_wdata_o (mwdata),
      .mem_rdata_i (mrdata)
    );

    initial for (int i = 0; i < (1 << AB); i++) mem[i] = init_val(gi, i);

    // single-port RAM: one access per edge, read data one cycle later
    always @(posedge clk) begin
      if (mcs) begin
        if (mwren) mem[maddr] <= mwdata;
        else       mrdata     <= mem[maddr];
      end
    end

    always @(negedge clk) begin : mon
      rec_t     e;
      bit [7:0] ev;
      if (expq[gi].size() != 0) begin
        e = expq[gi].pop_front();
        check(gi, "a_gnt",     32'(a_if.gnt),    32'(e.ga));
        check(gi, "b_gnt",     32'(b_if.gnt),    32'(e.gb));
        check(gi, "a_rvalid",  32'(a_if.rvalid), 32'(e.rva));
        check(gi, "b_rvalid",  32'(b_if.rvalid), 32'(e.rvb));
        check(gi, "mem_cs",    32'(mcs),         32'(e.ga | e.gb));
        check(gi, "mem_wren",  32'(mwren),       32'(e.wren));
        check(gi, "mem_addr",  32'(maddr),       32'(e.addr));
        check(gi, "mem_wdata", 32'(mwdata),      32'(e.wdata));
        for (int p = 0; p < 2; p++) begin
          if (rv_l[p]) begin
            if (rdq[gi*2+p].size() == 0) begin
              check(gi, (p == 0) ? "a_rvalid_unexpected" : "b_rvalid_unexpected", 32'd1, 32'd0);
            end else begin
              ev = rdq[gi*2+p].pop_front();
              check(gi, (p == 0) ? "a_rdata" : "b_rdata", 32'(rd_l[p]), 32'(ev));
            end
          end
          if (reset) begin
            waitc[p] <= 0;
          end else if (req_d[gi][p] && !gnt_l[p]) begin
            waitc[p] <= waitc[p] + 1;
          end else begin
            if (gnt_l[p]) check(gi, "wait_le_max_burst", 32'(waitc[p] <= MB), 32'd1);
            waitc[p] <= 0;
          end
        end
        if (mcs) begin
          $display("[TB] inst%0d t=%0t grant %s %s addr=0x%04h wdata=0x%02h",
                   gi, $time, a_if.gnt ? "A" : "B", mwren ? "WR" : "RD", maddr, mwdata);
        end
      end
    end
  end

  // stimulus-side pending operations and the reference model
  bit          pend    [NI][2];
  bit          p_wren  [NI][2];
  bit [AB-1:0] p_addr  [NI][2];
  bit [W-1:0]  p_wdata [NI][2];
  bit          rst_v;

  bit          m_last   [NI];
  int          m_run    [NI];
  bit          m_prevg  [NI];
  bit          m_rdpend [NI][2];
  bit [7:0]    ref_mem  [NI][1 << AB];

  task automatic post(int k, int p, bit wr, bit [AB-1:0] addr, bit [W-1:0] data);
    if (!pend[k][p]) begin
      pend[k][p]    = 1'b1;
      p_wren[k][p]  = wr;
      p_addr[k][p]  = addr;
      p_wdata[k][p] = data;
    end
  endtask

  function automatic bit [AB-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    return (r == 9) ? 15'h7FFF : AB'(r);
  endfunction

  // Predicts one cycle of arbiter behaviour from the current requests.
  task automatic model_eval(int k);
    rec_t e;
    int   g;
    e = '{default: '0};
    e.rva = m_rdpend[k][0];
    e.rvb = m_rdpend[k][1];
    if (rst_v) begin
      m_last[k]  = 1'b1;
      m_run[k]   = 0;
      m_prevg[k] = 1'b0;
      m_rdpend[k][0] = 1'b0;
      m_rdpend[k][1] = 1'b0;
    end else begin
      g = -1;
      if (pend[k][0] && pend[k][1])
        g = (m_prevg[k] && m_run[k] < mb_of(k)) ? int'(m_last[k]) : int'(!m_last[k]);
      else if (pend[k][0]) g = 0;
      else if (pend[k][1]) g = 1;
      m_rdpend[k][0] = 1'b0;
      m_rdpend[k][1] = 1'b0;
      if (g >= 0) begin
        e.ga    = (g == 0);
        e.gb    = (g == 1);
        e.wren  = p_wren[k][g];
        e.addr  = p_addr[k][g];
        e.wdata = p_wdata[k][g];
        m_run[k]   = (m_prevg[k] && g == int'(m_last[k])) ? m_run[k] + 1 : 1;
        m_last[k]  = (g == 1);
        m_prevg[k] = 1'b1;
        if (p_wren[k][g]) begin
          ref_mem[k][p_addr[k][g]] = p_wdata[k][g];
        end else begin
          m_rdpend[k][g] = 1'b1;
          rdq[k*2+g].push_back(ref_mem[k][p_addr[k][g]]);
        end
        pend[k][g] = 1'b0;
      end else begin
        m_prevg[k] = 1'b0;
        m_run[k]   = 0;
      end
    end
    expq[k].push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    reset = rst_v;
    for (int k = 0; k < NI; k++) begin
      for (int p = 0; p < 2; p++) begin
        req_d[k][p]   = pend[k][p];
        wren_d[k][p]  = p_wren[k][p];
        addr_d[k][p]  = p_addr[k][p];
        wdata_d[k][p] = p_wdata[k][p];
      end
    end
    for (int k = 0; k < NI; k++) model_eval(k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_v = 1'b1;
    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      m_last[k] = 1'b1; m_run[k] = 0; m_prevg[k] = 1'b0;
      for (int i = 0; i < (1 << AB); i++) ref_mem[k][i] = init_val(k, i);
      for (int p = 0; p < 2; p++) begin
        pend[k][p] = 1'b0; p_wren[k][p] = 1'b0; p_addr[k][p] = '0; p_wdata[k][p] = '0;
        m_rdpend[k][p] = 1'b0;
        req_d[k][p] = 1'b0; wren_d[k][p] = 1'b0; addr_d[k][p] = '0; wdata_d[k][p] = '0;
      end
    end
    repeat (2) @(posedge clk);
    repeat (3) step();
    rst_v = 1'b0;

    // write then read back on A
    post(0, 0, 1'b1, 15'h0010, 8'h5A); step();
    post(0, 0, 1'b0, 15'h0010, 8'h00); step();
    step();

    // B alone streams eight reads
    for (int i = 0; i < 8; i++) begin
      post(0, 1, 1'b0, 15'h0100 + 15'(i), 8'h00);
      step();
    end
    step();

    // A writes and B reads the top address in the same cycle
    post(0, 0, 1'b1, 15'h7FFF, 8'hC3);
    post(0, 1, 1'b0, 15'h7FFF, 8'h00);
    repeat (3) step();

    // continuous contention on both instances
    repeat (40) begin
      for (int k = 0; k < NI; k++)
        for (int p = 0; p < 2; p++)
          post(k, p, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
      step();
    end
    repeat (2) step();

    // reset straight after a read grant, reset with both requesting
    for (int k = 0; k < NI; k++) post(k, 0, 1'b0, 15'h0003, 8'h00);
    step();
    rst_v = 1'b1;
    for (int k = 0; k < NI; k++) begin
      post(k, 0, 1'b0, 15'h0004, 8'h00);
      post(k, 1, 1'b1, 15'h0004, 8'hE7);
    end
    repeat (2) step();
    rst_v = 1'b0;
    repeat (3) step();

    // random traffic with occasional drops and resets
    repeat (300) begin
      rst_v = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < NI; k++) begin
        for (int p = 0; p < 2; p++) begin
          int r;
          r = $urandom_range(0, 99);
          if (!pend[k][p] && r < 45)
            post(k, p, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
          else if (pend[k][p] && r < 3)
            pend[k][p] = 1'b0;
        end
      end
      step();
    end
    rst_v = 1'b0;
    for (int k = 0; k < NI; k++) begin
      pend[k][0] = 1'b0;
      pend[k][1] = 1'b0;
    end
    repeat (4) step();
    repeat (2) @(posedge clk);

    for (int k = 0; k < NI; k++) begin
      check(k, "expected_queue_drained", 32'(expq[k].size()), 32'd0);
      check(k, "a_read_queue_drained", 32'(rdq[k*2].size()), 32'd0);
      check(k, "b_read_queue_drained", 32'(rdq[k*2+1].size()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
